// File: rtl/img_pkg.sv
// ---------------------------------------------------------------------------
// img_pkg
// Shared definitions for the UART image-processing chain.
//   - uart_state_e : transmitter FSM states (IDLE/LOAD/START/DATA/STOP)
//   - UART_DATA_BITS / UART_STOP_BITS : 8N1 frame constants
//   - calc_bit_cyc() : sclk cycles per UART bit for a given clock and baud
// ---------------------------------------------------------------------------
package img_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } uart_state_e;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

    // Integer division: the bit period is truncated, never rounded up.
    function automatic int calc_bit_cyc(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a registered (one-cycle latency) read port.
// Ports:
//   sclk, rst_n       : clock, asynchronous active-low reset
//   wr_en, wr_data    : write strobe and data; ignored while full
//   rd_en, rd_data    : read strobe; rd_data valid the cycle after rd_en
//   full, empty       : status derived from the registered count
//   count             : number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the binary pointers wrap for free.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1024
) (
    input  logic                     sclk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    // Full/empty come from the pre-edge count, so a write while full is
    // dropped even if a read retires an entry on the same edge.
    assign full  = (r_count == CNT_FULL);
    assign empty = (r_count == '0);
    assign w_wr  = wr_en && !full;
    assign w_rd  = rd_en && !empty;

    // Storage and read register kept free of reset so they map onto block RAM.
    always_ff @(posedge sclk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
        if (w_rd) begin
            r_rd_data <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = r_rd_data;
    assign count   = r_count;

endmodule

// File: rtl/pix_uart_tx.sv
// ---------------------------------------------------------------------------
// pix_uart_tx
// Buffers the filtered pixel stream in a FIFO and sends each pixel as an
// 8N1 UART frame (LSB first).
// Ports:
//   sclk, rst_n : clock, asynchronous active-low reset
//   pi_data     : pixel value, valid with pi_flag
//   pi_flag     : one-cycle write strobe (may be high on consecutive cycles)
//   tx          : registered serial output, idle high
//   busy        : FSM not idle or FIFO not empty
//   fifo_full   : FIFO holds FIFO_DEPTH entries
//   ovf         : sticky, a pixel was dropped on a full FIFO
// ---------------------------------------------------------------------------
module pix_uart_tx
    import img_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 1024
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic [7:0] pi_data,
    input  logic       pi_flag,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       ovf
);

    localparam int BIT_CYC = calc_bit_cyc(CLK_FREQ, BAUD);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = $clog2(BIT_CYC);

    localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CYC - 1);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_LOAD  = ST_LOAD;
    localparam logic [2:0] S_START = ST_START;
    localparam logic [2:0] S_DATA  = ST_DATA;
    localparam logic [2:0] S_STOP  = ST_STOP;

    logic [2:0]    r_state;
    logic [CW-1:0] r_baud_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_ovf;

    logic          w_rd_en;
    logic          w_full;
    logic          w_empty;
    logic          w_bit_end;
    logic [7:0]    w_rd_data;
    logic [AW:0]   w_count;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sclk    (sclk),
        .rst_n   (rst_n),
        .wr_en   (pi_flag),
        .wr_data (pi_data),
        .rd_en   (w_rd_en),
        .rd_data (w_rd_data),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    assign w_bit_end = (r_baud_cnt == BAUD_LAST);

    // The read is issued one cycle ahead of LOAD so the registered FIFO
    // output is ready when LOAD latches it. Only issued when non-empty.
    assign w_rd_en = !w_empty &&
                     ((r_state == S_IDLE) || (r_state == S_STOP && w_bit_end));

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_ovf      <= 1'b0;
        end else begin
            if (pi_flag && w_full) begin
                r_ovf <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_empty) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_shift    <= w_rd_data;
                    r_tx       <= 1'b0;
                    r_baud_cnt <= '0;
                    r_state    <= S_START;
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_tx       <= r_shift[0];
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == LAST_BIT) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            // tx takes the bit that becomes the LSB after this shift
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_state    <= w_empty ? S_IDLE : S_LOAD;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CW'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx        = r_tx;
    assign busy      = (r_state != S_IDLE) || !w_empty;
    assign fifo_full = (w_count == CNT_FULL);
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_pix_uart_tx.sv
module tb_pix_uart_tx;

    logic       sclk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pi_data = 8'h00;
    logic       pi_flag = 1'b0;
    logic       tx, busy, fifo_full, ovf;

    logic [7:0] pi_data_d = 8'h00;
    logic       pi_flag_d = 1'b0;
    logic       tx_d, busy_d, full_d, ovf_d;

    always #5 sclk = ~sclk;

    int cyc = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    pix_uart_tx #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(4)) dut (
        .sclk(sclk), .rst_n(rst_n), .pi_data(pi_data), .pi_flag(pi_flag),
        .tx(tx), .busy(busy), .fifo_full(fifo_full), .ovf(ovf)
    );

    pix_uart_tx dut_def (
        .sclk(sclk), .rst_n(rst_n), .pi_data(pi_data_d), .pi_flag(pi_flag_d),
        .tx(tx_d), .busy(busy_d), .fifo_full(full_d), .ovf(ovf_d)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Frame monitor for the BIT_CYC=10 instance: detects a falling edge on tx,
    // samples each of the 10 bits mid-bit and queues {bits, start cycle}.
    logic [9:0] fr_bits[$];
    int         fr_start[$];
    int         n_starts = 0;

    initial begin : monitor
        logic [9:0] mon_bits;
        int  mon_cnt;
        int  mon_start;
        bit  mon_in;
        bit  prev_tx;
        mon_bits = '0; mon_cnt = 0; mon_start = 0; mon_in = 0; prev_tx = 1;
        forever begin
            @(negedge sclk);
            if (!rst_n) begin
                mon_in = 0;
            end else if (mon_in) begin
                mon_cnt++;
                if (mon_cnt % 10 == 5) mon_bits[mon_cnt / 10] = tx;
                if (mon_cnt == 95) begin
                    fr_bits.push_back(mon_bits);
                    fr_start.push_back(mon_start);
                    mon_in = 0;
                end
            end else if (prev_tx && !tx) begin
                mon_in    = 1;
                mon_cnt   = 0;
                mon_start = cyc;
                mon_bits  = '0;
                mon_bits[0] = tx;
                n_starts++;
            end
            prev_tx = tx;
        end
    end

    task automatic tick();
        @(negedge sclk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, output int wr_cyc);
        pi_flag = 1'b1;
        pi_data = d;
        tick();
        pi_flag = 1'b0;
        wr_cyc = cyc;
    endtask

    bit seen_full;
    bit seen_not_busy;

    task automatic wait_frames(input int n, input int bound);
        int k = 0;
        while (fr_bits.size() < n && k < bound) begin
            tick();
            k++;
            if (fifo_full) seen_full = 1;
            if (!busy) seen_not_busy = 1;
        end
        if (fr_bits.size() < n) check("frame_wait_timeout", fr_bits.size(), n);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 3000) begin
            tick();
            k++;
        end
        if (busy) check("idle_wait_timeout", busy, 0);
        repeat (5) tick();
        fr_bits.delete();
        fr_start.delete();
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit0 = start bit, bit9 = stop bit
    } vec_t;

    vec_t vecs[5];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int wc, s0, n0, n;
        logic [7:0] burst[4];
        logic [9:0] burst_fr[4];
        logic [9:0] ovf_fr[5];

        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h3C, 10'b1001111000};
        vecs[4] = '{8'h81, 10'b1100000010};

        burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h3C; burst[3] = 8'h81;
        burst_fr[0] = 10'b1000000000; burst_fr[1] = 10'b1111111110;
        burst_fr[2] = 10'b1001111000; burst_fr[3] = 10'b1100000010;

        ovf_fr[0] = 10'b1000000010; ovf_fr[1] = 10'b1000000100;
        ovf_fr[2] = 10'b1000000110; ovf_fr[3] = 10'b1000001000;
        ovf_fr[4] = 10'b1000001010;

        // Reset values
        repeat (3) tick();
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_full", fifo_full, 0);
        check("rst_ovf", ovf, 0);
        check("rst_def_outs", {tx_d, busy_d, full_d, ovf_d}, 4'b1000);
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_tx", tx, 1);
        check("post_rst_busy", busy, 0);

        // Table: single frames, latency, bit pattern, busy fall
        for (int i = 0; i < 5; i++) begin
            wait_idle();
            send(vecs[i].data, wc);
            wait_frames(1, 200);
            if (fr_bits.size() >= 1) begin
                check($sformatf("frame_%02h", vecs[i].data), fr_bits[0], vecs[i].frame);
                check($sformatf("latency_%02h", vecs[i].data), fr_start[0] - wc, 2);
                s0 = fr_start[0];
                n = 0;
                while (cyc < s0 + 99 && n < 200) begin tick(); n++; end
                check($sformatf("busy_at99_%02h", vecs[i].data), busy, 1);
                tick();
                check($sformatf("busy_at100_%02h", vecs[i].data), busy, 0);
            end
        end

        // Burst of 4 on consecutive cycles
        wait_idle();
        seen_full = 0;
        pi_flag = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pi_data = burst[i];
            tick();
            if (i == 0) wc = cyc;
            if (fifo_full) seen_full = 1;
        end
        pi_flag = 1'b0;
        wait_frames(4, 600);
        check("burst_full_never", seen_full, 0);
        check("burst_ovf", ovf, 0);
        if (fr_bits.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("burst_frame%0d", i), fr_bits[i], burst_fr[i]);
                check($sformatf("burst_start%0d", i), fr_start[i] - wc, 2 + 101 * i);
            end
        end

        // Overflow: 7 pixels into a depth-4 FIFO
        wait_idle();
        pi_flag = 1'b1;
        for (int i = 0; i < 7; i++) begin
            pi_data = 8'(i + 1);
            tick();
            check($sformatf("ovf_after_w%0d", i + 1), ovf, (i >= 5) ? 1 : 0);
            check($sformatf("full_after_w%0d", i + 1), fifo_full, (i >= 4) ? 1 : 0);
        end
        pi_flag = 1'b0;
        wait_frames(5, 700);
        repeat (150) tick();
        check("ovf_frame_count", fr_bits.size(), 5);
        if (fr_bits.size() >= 5) begin
            for (int i = 0; i < 5; i++)
                check($sformatf("ovf_frame%0d", i), fr_bits[i], ovf_fr[i]);
        end
        check("ovf_sticky", ovf, 1);

        // Write during transmission
        wait_idle();
        seen_not_busy = 0;
        send(8'h55, wc);
        n = 0;
        while (cyc < wc + 2 + 50 && n < 100) begin
            tick();
            n++;
            if (!busy) seen_not_busy = 1;
        end
        send(8'hAA, n0);
        wait_frames(2, 300);
        check("wdt_busy_continuous", seen_not_busy, 0);
        if (fr_bits.size() >= 2) begin
            check("wdt_frame0", fr_bits[0], 10'b1010101010);
            check("wdt_frame1", fr_bits[1], 10'b1101010100);
            check("wdt_period", fr_start[1] - fr_start[0], 101);
        end

        // Reset mid-frame during data bit 3 of 0xF0, two pixels queued
        wait_idle();
        pi_flag = 1'b1;
        pi_data = 8'hF0; tick(); wc = cyc;
        pi_data = 8'h11; tick();
        pi_data = 8'h22; tick();
        pi_flag = 1'b0;
        n = 0;
        while (cyc < wc + 2 + 45 && n < 100) begin tick(); n++; end
        check("mid_tx_low_before_rst", tx, 0);
        check("mid_ovf_before_rst", ovf, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ovf", ovf, 0);
        check("mid_rst_full", fifo_full, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        n0 = n_starts;
        repeat (300) tick();
        check("mid_no_new_frame", n_starts - n0, 0);
        check("mid_idle_tx", tx, 1);
        check("mid_idle_busy", busy, 0);

        // Defaults: 0x5A -> start + bit0 low (868), bit1 high (434)
        pi_flag_d = 1'b1;
        pi_data_d = 8'h5A;
        tick();
        pi_flag_d = 1'b0;
        wc = cyc;
        n = 0;
        while (tx_d && n < 10) begin tick(); n++; end
        check("def_latency", cyc - wc, 2);
        n = 0;
        while (!tx_d && n < 2000) begin tick(); n++; end
        check("def_low_run", n, 868);
        n = 0;
        while (tx_d && n < 2000) begin tick(); n++; end
        check("def_bit1_len", n, 434);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pix_uart_tx.md
# pix_uart_tx

Output stage of the UART image-processing chain. It accepts the 8-bit filtered pixel stream from the median filter (`po_flag`/`tx_data[7:0]` into `pi_flag`/`pi_data`) and buffers it in an internal synchronous FIFO. It then serializes each pixel as an 8N1 UART frame on `tx`, which decouples the one-pixel-per-cycle burst rate from the much slower line rate.

## Interface
- `CLK_FREQ`, 50_000_000: sclk frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `FIFO_DEPTH`, 1024: pixel buffer depth; must be a power of two, ≥ 4.
- Derived, not overridable:
  - `BIT_CYC = CLK_FREQ/BAUD` (integer division, 434 at defaults); must be ≥ 2.
  - `AW = clog2(FIFO_DEPTH)`.
- `sclk` in 1: clock, all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `pi_data` in 8: pixel value, valid when `pi_flag` = 1.
- `pi_flag` in 1: one-cycle write strobe; may be high on consecutive cycles.
- `tx` out 1: UART serial output; idle high.
- `busy` out 1: high while the FSM is not IDLE or the FIFO is non-empty.
- `fifo_full` out 1: FIFO holds `FIFO_DEPTH` entries.
- `ovf` out 1: sticky; a pixel was dropped because the FIFO was full.

## Operation
- **Write:**
  - On an edge with `pi_flag`=1 and the FIFO not full, `pi_data` is stored.
  - If the FIFO is full, the pixel is discarded and `ovf` is set. `ovf` is cleared only by reset.
  - The full check uses the pre-edge count, so a write while full is dropped even if a read happens on the same edge.
- **Read:**
  - Synchronous, one-cycle latency: `rd_en` at edge N presents data after edge N.
  - A simultaneous write and read leave the count unchanged.
  - A read while empty never occurs; the FSM guarantees this.
- **FSM states:** IDLE, LOAD, START, DATA, STOP.
  - IDLE: `tx`=1. If not empty, assert `rd_en` and go to LOAD.
  - LOAD: latch FIFO output into an 8-bit shift register, drive `tx`=0, clear the baud counter, go to START.
  - START: hold `tx`=0 for `BIT_CYC` cycles, then go to DATA with bit index 0.
  - DATA:
    - Drive `tx` with the shift register LSB for `BIT_CYC` cycles per bit, shifting right after each bit. Order is LSB first.
    - After bit index 7 completes, drive `tx`=1 and go to STOP.
  - STOP:
    - Hold `tx`=1 for `BIT_CYC` cycles.
    - At the end of STOP, if not empty, assert `rd_en` and go directly to LOAD; otherwise go to IDLE.
- **Baud counter:** 0…`BIT_CYC`-1. It wraps to 0 on each bit boundary and is reset on entry to START.
- `tx` is a registered output with no combinational path from state.
- **Reset asserted mid-frame:**
  - `tx` goes to 1 immediately.
  - FSM goes to IDLE; FIFO pointers and count go to 0; shift register is cleared; `ovf` = 0.
  - The partial frame is abandoned.

## Timing
- **Reset values:** `tx`=1, `busy`=0, `fifo_full`=0, `ovf`=0.
- **First-pixel latency** (`pi_flag` sampled at edge E0 with FIFO empty and FSM in IDLE):
  - E0: write.
  - E1: IDLE issues the read.
  - E2: LOAD; `tx` falls.
- **Frame length:** 10·`BIT_CYC` cycles from the `tx` falling edge to the end of STOP.
- **Back-to-back frames:** one LOAD cycle with `tx`=1 between the end of STOP and the next start bit, so the frame period is 10·`BIT_CYC`+1 cycles.
- `fifo_full` and `busy` are registered/derived from registered state and update the cycle after the causing edge. `ovf` rises on the edge that drops the pixel.

## Structure
- Shared package `img_pkg`:
  - FSM state enum (IDLE/LOAD/START/DATA/STOP).
  - Helper function computing `BIT_CYC` from `CLK_FREQ`/`BAUD`.
  - UART constants: 8 data bits, 1 stop bit.
- One sub-module, `sync_fifo`:
  - Parameters: width 8, depth `FIFO_DEPTH`.
  - Ports: `wr_en`, `wr_data`, `rd_en`, `rd_data`, `full`, `empty`, count.
  - Binary pointers plus an (AW+1)-bit count; async reset.
- The top level holds the FSM, baud counter, bit index, shift register, and `ovf`.

## Test plan
All scenarios use `CLK_FREQ`=1000, `BAUD`=100 (`BIT_CYC`=10) and `FIFO_DEPTH`=4 unless stated.

- **Single byte:** `pi_data`=0xA5 for one cycle.
  - `tx` falls 2 edges later.
  - Bits sampled mid-bit are 0,1,0,1,0,0,1,0,1,1 (start, LSB-first 0xA5, stop).
  - `busy` falls after 100 cycles.
- **Burst of 4:** 0x00, 0xFF, 0x3C, 0x81 on consecutive cycles.
  - Four frames in order, each period 101 cycles.
  - `fifo_full` = 0 throughout, because one entry drains at E1.
  - `ovf` = 0.
- **Overflow:** 7 consecutive pixels 0x01…0x07.
  - 0x01–0x05 are transmitted; 0x06 and 0x07 are dropped.
  - `ovf` = 1 from the 0x06 write edge onward.
  - `fifo_full` = 1 while 4 entries are held.
- **Write during transmission:** write 0x55, then 0xAA at cycle 50 of the first frame.
  - Second start bit begins exactly 101 cycles after the first.
  - `busy` stays high continuously.
- **Reset mid-frame:** assert `rst_n`=0 during bit 3 of 0xF0 with 2 pixels queued.
  - `tx`=1 immediately, `busy`=0, `ovf`=0.
  - After release, no frame is sent without a new `pi_flag`.
- **Defaults sanity:** with defaults, the first bit of 0x5A lasts 434 cycles.
